// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters; optional LAUNCH watchdog under UART_TX_ARB_TIMEOUT_EN.
// Latency: 1 cycle from a pending request seen in IDLE with tx_ready=1 to req_ack/tx_start.
// Backpressure: no grant while tx_ready=0 or a frame is in flight; requesters hold req_valid/req_data until req_ack.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                 err_timeout
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDW) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    state_t               state;
    logic [IDW-1:0]       last_grant;

    logic                 found_hi;
    logic                 found_lo;
    logic [IDW-1:0]       win_hi;
    logic [IDW-1:0]       win_lo;
    logic [IDW-1:0]       winner;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [7:0]           win_byte;

    // Two-pass round-robin: lowest valid index above last_grant, else lowest valid overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_lo = 1'b1;
                win_lo   = IDW'(i);
                if (i > int'(last_grant)) begin
                    found_hi = 1'b1;
                    win_hi   = IDW'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_onehot = '0;
        win_byte   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(winner) == i) begin
                win_onehot[i] = 1'b1;
                win_byte      = req_data[8*i +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] launch_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            req_ack    <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
            launch_cnt  <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            req_ack <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (tx_ready && found_lo) begin
                        req_ack    <= win_onehot;
                        grant_id   <= winner;
                        last_grant <= winner;
                        tx_data    <= win_byte;
                        tx_start   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        launch_cnt <= '0;
`endif
                    end
                end
                LAUNCH: begin
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        state    <= BUSY;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // Transmitter never took the byte: drop it, keep last_grant so rotation continues.
                    else if (launch_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        tx_start    <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        launch_cnt <= launch_cnt + 1'b1;
                    end
`endif
                end
                BUSY: begin
                    if (tx_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for uart_tx_arbiter (NUM_REQ=4).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic        err_timeout;
`endif

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .IDW(2), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [3:0] v;
        logic [3:0] ack;
        logic       start;
        logic       bsy;
        logic [1:0] gid;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic rdy, logic [3:0] v, logic [3:0] ack, logic start,
                                logic bsy, logic [1:0] gid, logic [7:0] dat);
        vec_t r;
        r.rdy = rdy; r.v = v; r.ack = ack; r.start = start; r.bsy = bsy; r.gid = gid; r.dat = dat;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        req_valid = 4'b0000;
        tx_ready  = 1'b1;
        edge_sample();
        edge_sample();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr;
        int frames;
        int frame;
        logic prev_busy;

        req_data  = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        reset     = 1'b1;
        req_valid = 4'b0000;
        tx_ready  = 1'b1;
        #12;
        check("reset_ack",   32'(req_ack),  0);
        check("reset_start", 32'(tx_start), 0);
        check("reset_busy",  32'(busy),     0);
        check("reset_gid",   32'(grant_id), 0);
        check("reset_data",  32'(tx_data),  0);
        edge_sample();
        reset = 1'b0;

        vecs[0]  = mk(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hA5);
        vecs[1]  = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 8'hA5);
        vecs[2]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5);
        vecs[3]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5);
        vecs[4]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5);
        vecs[5]  = mk(1'b1, 4'b1111, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h3C);
        vecs[6]  = mk(1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h3C);
        vecs[7]  = mk(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h3C);
        vecs[8]  = mk(1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h11);
        vecs[9]  = mk(1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h11);
        vecs[10] = mk(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h11);
        vecs[11] = mk(1'b1, 4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h5A);
        vecs[12] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h5A);
        vecs[13] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h5A);
        vecs[14] = mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h5A);
        vecs[15] = mk(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h5A);
        vecs[16] = mk(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h11);
        vecs[17] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h11);
        vecs[18] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h11);
        vecs[19] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h11);

        for (int i = 0; i < 20; i++) begin
            tx_ready  = vecs[i].rdy;
            req_valid = vecs[i].v;
            edge_sample();
            check($sformatf("vec%0d_ack", i),   32'(req_ack),  32'(vecs[i].ack));
            check($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vecs[i].start));
            check($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].bsy));
            check($sformatf("vec%0d_gid", i),   32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("vec%0d_data", i),  32'(tx_data),  32'(vecs[i].dat));
        end

        // Round robin against a 10-cycle transmitter model.
        reset_dut();
        req_valid = 4'b1111;
        ngr       = 0;
        frames    = 0;
        frame     = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 300 && ngr < 5; c++) begin
            edge_sample();
            if (req_ack != 4'b0000) begin
                check("rr_onehot", 32'($countones(req_ack)), 1);
                check("rr_idle_gap", 32'(prev_busy), 0);
                check($sformatf("rr_order%0d", ngr), 32'(req_ack), 32'(4'b0001 << (ngr % 4)));
                check($sformatf("rr_gid%0d", ngr), 32'(grant_id), 32'(ngr % 4));
                ngr++;
            end
            prev_busy = busy;
            if (tx_start && tx_ready) begin
                tx_ready = 1'b0;
                frame    = 10;
                frames++;
            end else if (frame > 0) begin
                frame--;
                if (frame == 0) tx_ready = 1'b1;
            end
        end
        check("rr_grants", 32'(ngr), 5);
        check("rr_frames_per_ack", 32'(frames), 32'(ngr));

        // Asynchronous reset while a frame is in flight.
        reset_dut();
        req_valid = 4'b0100;
        edge_sample();
        req_valid = 4'b0000;
        tx_ready  = 1'b0;
        edge_sample();
        check("mid_busy_before", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_start", 32'(tx_start), 0);
        check("mid_rst_busy",  32'(busy),     0);
        check("mid_rst_ack",   32'(req_ack),  0);
        check("mid_rst_gid",   32'(grant_id), 0);
        edge_sample();
        reset     = 1'b0;
        tx_ready  = 1'b1;
        req_valid = 4'b1111;
        edge_sample();
        check("mid_rst_first_ack", 32'(req_ack), 32'(4'b0001));
        req_valid = 4'b0000;

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Transmitter stuck ready: watchdog fires after 16 LAUNCH cycles.
        reset_dut();
        req_valid = 4'b0001;
        edge_sample();
        check("to_launch", 32'(tx_start), 1);
        req_valid = 4'b0000;
        for (int k = 1; k < 16; k++) begin
            edge_sample();
            check($sformatf("to_wait%0d", k), 32'({tx_start, err_timeout}), 32'(2'b10));
        end
        edge_sample();
        check("to_err",   32'(err_timeout), 1);
        check("to_start", 32'(tx_start),   0);
        check("to_busy",  32'(busy),       0);
        edge_sample();
        check("to_err_pulse", 32'(err_timeout), 0);
        check("to_idle",      32'({tx_start, busy}), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
